// File: rtl/cs_component.sv
// Carrier-sense detector: instantaneous power of each accepted I/Q sample,
// moving average over a 2^LOG2_WIN window, registered threshold compare.
module cs_component #(
   parameter logic [7:0]  SR_ENABLE      = 8'd1,
   parameter logic [7:0]  SR_THRESH      = 8'd2,
   parameter int          LOG2_WIN       = 4,
   parameter logic [31:0] DEFAULT_THRESH = 32'd100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        set_stb_user,
   input  logic [7:0]  set_addr_user,
   input  logic [31:0] set_data_user,
   input  logic [15:0] real_value,
   input  logic [15:0] img_value,
   input  logic        strobe,
   input  logic        run,
   output logic        present_next
);

   localparam int WIN   = 1 << LOG2_WIN;
   localparam int SUM_W = LOG2_WIN + 32;

   logic                enable_q, enable_d;
   logic [31:0]         thresh_q, thresh_d;
   logic [31:0]         pwr_q, pwr_d;
   logic                pwr_vld_q, pwr_vld_d;
   logic [31:0]         win_q [WIN];
   logic [LOG2_WIN-1:0] ptr_q;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic                present_q, present_d;
   logic [31:0]         average;
   logic                sample_acc;
   logic signed [31:0]  re_sq, im_sq;

   // Settings bus decode: enable and threshold next-state.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      enable_d = enable_q;
      thresh_d = thresh_q;
      if (set_stb_user) begin
         if (set_addr_user == SR_ENABLE) enable_d = set_data_user[0];
         if (set_addr_user == SR_THRESH) thresh_d = set_data_user;
      end
   end

   // Power stage and window-sum next-state.
   always_comb begin
      sample_acc = strobe & run;
      re_sq      = $signed(real_value) * $signed(real_value);
      im_sq      = $signed(img_value) * $signed(img_value);
      pwr_vld_d  = sample_acc;
      pwr_d      = pwr_q;
      if (sample_acc) pwr_d = unsigned'(re_sq) + unsigned'(im_sq);
      sum_d = sum_q;
      if (pwr_vld_q)
         sum_d = sum_q + {{LOG2_WIN{1'b0}}, pwr_q} - {{LOG2_WIN{1'b0}}, win_q[ptr_q]};
   end

   // Average is the window sum divided by the window length (truncating).
   always_comb begin
      average   = sum_q[SUM_W-1:LOG2_WIN];
      present_d = enable_q & run & (average > thresh_q);
   end

   // Settings registers; reset restores enable and the default threshold.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst) begin
         enable_q <= 1'b1;
         thresh_q <= DEFAULT_THRESH;
      end else begin
         enable_q <= enable_d;
         thresh_q <= thresh_d;
      end
   end

   // Power register, circular window buffer, pointer and running sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwr_q     <= '0;
         pwr_vld_q <= 1'b0;
         ptr_q     <= '0;
         sum_q     <= '0;
         // NOTE: the window buffer is reset on purpose: the running sum assumes unfilled entries are zero.
         for (int i = 0; i < WIN; i++) win_q[i] <= '0;
      end else begin
         pwr_q     <= pwr_d;
         pwr_vld_q <= pwr_vld_d;
         sum_q     <= sum_d;
         if (pwr_vld_q) begin
            win_q[ptr_q] <= pwr_q;
            ptr_q        <= ptr_q + 1'b1;
         end
      end
   end

   // Registered carrier-present decision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) present_q <= 1'b0;
      else     present_q <= present_d;
   end

   assign present_next = present_q;

endmodule

// File: tb/tb_cs_component.sv
// Scoreboard bench for cs_component: stimulus pushes per-cycle expectations
// from a window-of-powers model; a monitor pops and compares after each edge.
module tb_cs_component;

   logic        clk;
   logic        rst;
   logic        set_stb_user;
   logic [7:0]  set_addr_user;
   logic [31:0] set_data_user;
   logic [15:0] real_value;
   logic [15:0] img_value;
   logic        strobe;
   logic        run;
   logic        present_next;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        p;
      logic [31:0] avg;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: list of the last 16 powers, settings, one pending power.
   longint unsigned window_m[$];
   logic            en_m;
   logic [31:0]     th_m;
   logic            pend_v;
   longint unsigned pend_pw;

   cs_component dut (
      .clk          (clk),
      .rst          (rst),
      .set_stb_user (set_stb_user),
      .set_addr_user(set_addr_user),
      .set_data_user(set_data_user),
      .real_value   (real_value),
      .img_value    (img_value),
      .strobe       (strobe),
      .run          (run),
      .present_next (present_next)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint unsigned model_avg();
      longint unsigned s = 0;
      foreach (window_m[i]) s += window_m[i];
      return s / 16;
   endfunction

   task automatic model_reset();
      window_m.delete();
      en_m    = 1'b1;
      th_m    = 32'd100;
      pend_v  = 1'b0;
      pend_pw = 0;
   endtask

   // One clock of stimulus; expectation describes outputs after the coming edge.
   task automatic step(input logic stb, input logic rn, input logic [15:0] re, input logic [15:0] im,
                       input logic wr, input logic [7:0] addr, input logic [31:0] data);
      exp_t    e;
      longint  rs, is;
      @(negedge clk);
      strobe        = stb;
      run           = rn;
      real_value    = re;
      img_value     = im;
      set_stb_user  = wr;
      set_addr_user = addr;
      set_data_user = data;
      e.p = en_m & rn & (model_avg() > longint'(th_m));
      if (pend_v) begin
         window_m.push_back(pend_pw);
         if (window_m.size() > 16) void'(window_m.pop_front());
      end
      e.avg  = 32'(model_avg());
      pend_v = stb & rn;
      rs = longint'($signed(re));
      is = longint'($signed(im));
      pend_pw = longint'(rs * rs + is * is);
      if (wr && addr == 8'd1) en_m = data[0];
      if (wr && addr == 8'd2) th_m = data;
      exp_q.push_back(e);
   endtask

   task automatic sample(input logic stb, input logic rn, input logic [15:0] re, input logic [15:0] im);
      step(stb, rn, re, im, 1'b0, 8'd0, 32'd0);
   endtask

   task automatic write(input logic [7:0] addr, input logic [31:0] data);
      step(1'b0, 1'b1, 16'd0, 16'd0, 1'b1, addr, data);
   endtask

   task automatic settle();
      @(posedge clk);
      #3;
   endtask

   // Asynchronous reset between edges; outputs must clear at once.
   task automatic do_reset(input string tag);
      settle();
      strobe       = 1'b0;
      run          = 1'b0;
      set_stb_user = 1'b0;
      rst          = 1'b1;
      #1;
      check({tag, "_present"}, 64'(present_next), 64'd0);
      check({tag, "_average"}, 64'(dut.average), 64'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: compare one expectation per completed edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("present_next", 64'(present_next), 64'(e.p));
            check("average", 64'(dut.average), 64'(e.avg));
         end
      end
   end

   initial begin
      rst = 1'b1; strobe = 1'b0; run = 1'b0; real_value = '0; img_value = '0;
      set_stb_user = 1'b0; set_addr_user = '0; set_data_user = '0;
      model_reset();
      #1;
      check("init_present", 64'(present_next), 64'd0);
      check("init_average", 64'(dut.average), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Basic stream.
      repeat (100) sample(1'b1, 1'b1, 16'd20, 16'd20);
      settle();
      check("basic_present", 64'(present_next), 64'd1);
      check("basic_average", 64'(dut.average), 64'd800);

      // Disabled detection.
      do_reset("rst1");
      write(8'd1, 32'd0);
      repeat (30) sample(1'b1, 1'b1, 16'd20, 16'd20);
      settle();
      check("disable_present", 64'(present_next), 64'd0);
      check("disable_average", 64'(dut.average), 64'd800);

      // Unreachable threshold.
      do_reset("rst2");
      write(8'd2, 32'hFFFF_FFFF);
      repeat (30) sample(1'b1, 1'b1, 16'h8000, 16'h8000);
      settle();
      check("maxthr_present", 64'(present_next), 64'd0);

      // Equality does not trigger; one below does.
      do_reset("rst3");
      write(8'd2, 32'd800);
      repeat (30) sample(1'b1, 1'b1, 16'hFFEC, 16'd20);
      settle();
      check("equal_present", 64'(present_next), 64'd0);
      write(8'd2, 32'd799);
      repeat (3) sample(1'b0, 1'b1, 16'd0, 16'd0);
      settle();
      check("below_present", 64'(present_next), 64'd1);

      // Run gating: a single accepted sample.
      do_reset("rst4");
      sample(1'b1, 1'b1, 16'd20, 16'd20);
      repeat (30) sample(1'b1, 1'b0, 16'd20, 16'd20);
      settle();
      check("rungate_average", 64'(dut.average), 64'd50);
      check("rungate_present", 64'(present_next), 64'd0);

      // Sparse strobes.
      do_reset("rst5");
      repeat (5) begin
         sample(1'b1, 1'b1, 16'd20, 16'd20);
         repeat (10) sample(1'b0, 1'b1, 16'd20, 16'd20);
      end
      repeat (30) sample(1'b0, 1'b1, 16'd20, 16'd20);
      settle();
      check("sparse_average", 64'(dut.average), 64'd250);
      check("sparse_present", 64'(present_next), 64'd1);

      // Reset mid-run after lowering the threshold; defaults must return.
      write(8'd2, 32'd50);
      repeat (3) sample(1'b0, 1'b1, 16'd0, 16'd0);
      settle();
      check("midrun_before", 64'(present_next), 64'd1);
      do_reset("midrun");
      repeat (30) sample(1'b1, 1'b1, 16'd7, 16'd3);
      settle();
      check("midrun_thresh_restored", 64'(present_next), 64'd0);
      repeat (30) sample(1'b1, 1'b1, 16'd10, 16'd1);
      settle();
      check("midrun_enable_restored", 64'(present_next), 64'd1);

      // Randomized traffic with interleaved settings writes.
      do_reset("rst6");
      for (int n = 0; n < 600; n++) begin
         logic        stb, rn, wr;
         logic [15:0] re, im;
         logic [7:0]  addr;
         logic [31:0] data;
         int          v;
         stb = ($urandom_range(0, 3) != 0);
         rn  = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 4) != 0) begin
            v = int'($urandom_range(0, 80)) - 40; re = 16'(v);
            v = int'($urandom_range(0, 80)) - 40; im = 16'(v);
         end else begin
            re = 16'($urandom);
            im = 16'($urandom);
         end
         wr   = ($urandom_range(0, 15) == 0);
         addr = 8'($urandom_range(1, 3));
         if (addr == 8'd1) data = {31'($urandom), ($urandom_range(0, 3) != 0)};
         else if ($urandom_range(0, 7) == 0) data = $urandom;
         else data = 32'($urandom_range(0, 2500));
         step(stb, rn, re, im, wr, addr, data);
      end

      settle();
      settle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
